// File: rtl/dec_sel_sequencer.sv
// dec_sel_sequencer: registered 2-bit select/enable generator for the 2-to-4 decoder
module dec_sel_sequencer #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_i,
   input  logic             mode_i,
   input  logic             dir_i,
   input  logic             step_i,
   input  logic [1:0]       man_sel_i,
   input  logic [DIV_W-1:0] div_i,
   output logic [1:0]       sel_o,
   output logic             en_o,
   output logic             wrap_o,
   output logic [1:0]       state_o
);
   typedef enum logic [1:0] {IDLE = 2'b00, MANUAL = 2'b01, SCAN = 2'b10} state_t;
   state_t state, nxt;
   logic [DIV_W-1:0] cnt;
   logic s1, s2, prev, stp;
   assign state_o = state;
   assign stp = s2 & ~prev;
   // target state depends only on run/mode, whatever the current state
   always_comb nxt = !run_i ? IDLE : (mode_i ? SCAN : MANUAL);
   // pad step synchroniser plus previous-value flop for rising-edge detect
   always_ff @(posedge clk) begin
      if (rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         prev <= 1'b0;
      end else begin
         s1   <= step_i;
         s2   <= s1;
         prev <= s2;
      end
   end
   // state, divider, select and flags; a state change suppresses any advance or load
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         sel_o  <= 2'd0;
         en_o   <= 1'b0;
         wrap_o <= 1'b0;
         cnt    <= '0;
      end else begin
         state  <= nxt;
         en_o   <= nxt != IDLE;
         wrap_o <= 1'b0;
         if (nxt != state) cnt <= '0;
         else if (state == SCAN) begin
            if (cnt >= div_i) begin
               cnt    <= '0;
               sel_o  <= dir_i ? sel_o - 2'd1 : sel_o + 2'd1;
               wrap_o <= dir_i ? sel_o == 2'd0 : sel_o == 2'd3;
            end else cnt <= cnt + DIV_W'(1);
         end else if (state == MANUAL && stp) sel_o <= man_sel_i;
      end
   end
endmodule

// File: tb/tb_dec_sel_sequencer.sv
// tb_dec_sel_sequencer: directed spec scenarios plus random stimulus against a cycle model
module tb_dec_sel_sequencer;
   localparam int DIV_W = 16;
   logic clk = 1'b0;
   logic rst, run, mode, dir, step;
   logic [1:0] man_sel;
   logic [DIV_W-1:0] div;
   logic [1:0] sel, state;
   logic en, wrap;
   int checks = 0, errors = 0;
   int m_sel, m_st, m_cnt;
   bit m_en, m_wrap;
   bit [2:0] hist;
   always #5 clk = ~clk;
   dec_sel_sequencer #(.DIV_W(DIV_W)) dut (
      .clk(clk), .rst(rst), .run_i(run), .mode_i(mode), .dir_i(dir), .step_i(step),
      .man_sel_i(man_sel), .div_i(div), .sel_o(sel), .en_o(en), .wrap_o(wrap), .state_o(state)
   );
   task automatic check(string tag, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   // model: states 0 idle, 1 manual, 2 scan; hist[0] newest step sample
   task automatic model();
      int nst;
      bit e;
      e = hist[1] & ~hist[2];
      m_wrap = 1'b0;
      if (rst) begin
         m_st = 0; m_sel = 0; m_en = 1'b0; m_cnt = 0; hist = 3'b000;
         return;
      end
      nst = !run ? 0 : (mode ? 2 : 1);
      if (nst != m_st) m_cnt = 0;
      else if (m_st == 2) begin
         if (m_cnt >= int'(div)) begin
            m_cnt = 0;
            m_sel = (m_sel + (dir ? 3 : 1)) % 4;
            m_wrap = dir ? (m_sel == 3) : (m_sel == 0);
         end else m_cnt++;
      end else if (m_st == 1 && e) m_sel = int'(man_sel);
      m_st = nst;
      m_en = nst != 0;
      hist = {hist[1:0], step};
   endtask
   task automatic cyc(int n = 1);
      repeat (n) begin
         @(posedge clk);
         model();
         @(negedge clk);
         check("sel", sel, m_sel);
         check("en", en, m_en);
         check("wrap", wrap, m_wrap);
         check("state", state, m_st);
      end
   endtask
   initial begin
      rst = 1'b1; run = 1'b0; mode = 1'b0; dir = 1'b0; step = 1'b0; man_sel = 2'd0; div = '0;
      m_sel = 0; m_st = 0; m_cnt = 0; m_en = 1'b0; m_wrap = 1'b0; hist = 3'b000;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         step = ~step;
         cyc();
      end
      check("rst_state", state, 0);
      check("rst_sel", sel, 0);
      rst = 1'b0; step = 1'b0; run = 1'b1; mode = 1'b0; man_sel = 2'd2;
      cyc(3);
      step = 1'b1;
      cyc(2);
      check("man_lat_k1", sel, 0);
      cyc(1);
      check("man_load", sel, 2);
      cyc(7);
      man_sel = 2'd1;
      cyc(5);
      check("man_hold", sel, 2);
      mode = 1'b1; dir = 1'b0; div = 16'd2;
      cyc(14);
      dir = 1'b1; div = '0;
      cyc(6);
      div = 16'd1000;
      cyc(500);
      div = 16'd10;
      cyc(30);
      run = 1'b0;
      cyc(3);
      check("idle_en", en, 0);
      run = 1'b1;
      cyc(5);
      rst = 1'b1;
      cyc(1);
      check("rst_pulse_state", state, 0);
      check("rst_pulse_en", en, 0);
      rst = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         rst = $urandom_range(199) == 0;
         run = $urandom_range(24) != 0;
         if ($urandom_range(29) == 0) mode = ~mode;
         if ($urandom_range(19) == 0) dir = ~dir;
         if ($urandom_range(15) == 0) div = DIV_W'($urandom_range(6));
         if ($urandom_range(3) == 0) step = ~step;
         man_sel = 2'($urandom);
         cyc();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
